// File: rtl/core_bus_arbiter_if.sv
// rtl/core_bus_arbiter_if.sv - core fetch/data ports and memory-side bus bundle
interface core_bus_arbiter_if;
  logic [18:0] instr_m_addr;
  logic [15:0] instr_m_data_in;
  logic        instr_m_access;
  logic        instr_m_ack;

  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_access;
  logic        data_m_ack;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        d_io;

  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_in;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_io;

  modport slave (
    input  instr_m_addr, instr_m_access,
    input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel, d_io,
    input  q_m_data_in, q_m_ack,
    output instr_m_data_in, instr_m_ack,
    output data_m_data_in, data_m_ack,
    output q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel, q_io
  );

  modport master (
    output instr_m_addr, instr_m_access,
    output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel, d_io,
    output q_m_data_in, q_m_ack,
    input  instr_m_data_in, instr_m_ack,
    input  data_m_data_in, data_m_ack,
    input  q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel, q_io
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// rtl/core_bus_arbiter.sv - data-priority fetch/data arbiter onto one memory bus
// Data wins contention until STARVE_LIMIT consecutive data grants have passed a waiting fetch.
module core_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  core_bus_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RETIRE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   starve_cnt_q, starve_cnt_d;

  assign bus.instr_m_data_in = bus.q_m_data_in;
  assign bus.data_m_data_in  = bus.q_m_data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    starve_cnt_d     = starve_cnt_q;
    bus.q_m_access   = 1'b0;
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = 2'b00;
    bus.q_io         = 1'b0;
    bus.instr_m_ack  = 1'b0;
    bus.data_m_ack   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.data_m_access && bus.instr_m_access) begin
          if (starve_cnt_q == LIMIT) begin
            state_d      = SERVE_I;
            starve_cnt_d = '0;
          end else begin
            state_d      = SERVE_D;
            starve_cnt_d = starve_cnt_q + CW'(1);
          end
        end else if (bus.data_m_access) begin
          state_d      = SERVE_D;
          starve_cnt_d = '0;
        end else if (bus.instr_m_access) begin
          state_d      = SERVE_I;
          starve_cnt_d = '0;
        end
      end

      SERVE_D: begin
        bus.q_m_access   = bus.data_m_access;
        bus.q_m_addr     = bus.data_m_addr;
        bus.q_m_data_out = bus.data_m_data_out;
        bus.q_m_wr_en    = bus.data_m_wr_en;
        bus.q_m_bytesel  = bus.data_m_bytesel;
        bus.q_io         = bus.d_io;
        bus.data_m_ack   = bus.q_m_ack && bus.data_m_access;
        // A withdrawn request aborts the cycle; any late memory ack lands in IDLE and is dropped.
        if (!bus.data_m_access) state_d = IDLE;
        else if (bus.q_m_ack)   state_d = RETIRE;
      end

      SERVE_I: begin
        bus.q_m_access  = bus.instr_m_access;
        bus.q_m_addr    = bus.instr_m_addr;
        bus.q_m_bytesel = 2'b11;
        bus.instr_m_ack = bus.q_m_ack && bus.instr_m_access;
        if (!bus.instr_m_access) state_d = IDLE;
        else if (bus.q_m_ack)    state_d = RETIRE;
      end

      // One dead cycle so a master still holding access after its ack is not re-granted.
      RETIRE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb/tb_core_bus_arbiter.sv - directed self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  core_bus_arbiter_if bus();

  core_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.instr_m_addr    = '0;
    bus.instr_m_access  = 1'b0;
    bus.data_m_addr     = '0;
    bus.data_m_data_out = '0;
    bus.data_m_access   = 1'b0;
    bus.data_m_wr_en    = 1'b0;
    bus.data_m_bytesel  = 2'b00;
    bus.d_io            = 1'b0;
    bus.q_m_data_in     = '0;
    bus.q_m_ack         = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack, bus.data_m_ack} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected 000", {bus.q_m_access, bus.instr_m_ack, bus.data_m_ack});
    end
    checks++;
    if ({bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io} !== 39'h0) begin
      failures++;
      $display("FAIL reset_bus: got addr=%h dout=%h we=%b bs=%b io=%b expected all 0",
               bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io);
    end
    checks++;
    if (dut.starve_cnt_q !== 3'd0) begin
      failures++;
      $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt_q);
    end
  endtask

  task automatic test_fetch();
    step();
    bus.instr_m_access = 1'b1;
    bus.instr_m_addr   = 19'h7FFF0;
    #1;
    checks++;
    if (bus.q_m_access !== 1'b0) begin
      failures++;
      $display("FAIL fetch_latency: q_m_access got %b expected 0 in request cycle", bus.q_m_access);
    end
    step();
    checks++;
    if ({bus.q_m_access, bus.q_m_addr, bus.q_m_bytesel, bus.q_m_wr_en, bus.q_io, bus.q_m_data_out} !== {1'b1, 19'h7FFF0, 2'b11, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL fetch_bus: got acc=%b addr=%h bs=%b we=%b io=%b dout=%h expected 1 7fff0 11 0 0 0000",
               bus.q_m_access, bus.q_m_addr, bus.q_m_bytesel, bus.q_m_wr_en, bus.q_io, bus.q_m_data_out);
    end
    step();
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_wait: got acc/ack=%b expected 10", {bus.q_m_access, bus.instr_m_ack});
    end
    step();
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'hBEEF;
    #1;
    checks++;
    if ({bus.instr_m_ack, bus.data_m_ack, bus.instr_m_data_in} !== {2'b10, 16'hBEEF}) begin
      failures++;
      $display("FAIL fetch_ack: got iack=%b dack=%b idata=%h expected 1 0 beef",
               bus.instr_m_ack, bus.data_m_ack, bus.instr_m_data_in);
    end
    step();
    bus.instr_m_access = 1'b0;
    bus.q_m_ack        = 1'b0;
    #1;
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack, bus.data_m_ack} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_retire: got %b expected 000", {bus.q_m_access, bus.instr_m_ack, bus.data_m_ack});
    end
    step();
  endtask

  task automatic test_data_io();
    bus.data_m_access   = 1'b1;
    bus.data_m_wr_en    = 1'b1;
    bus.data_m_bytesel  = 2'b01;
    bus.d_io            = 1'b1;
    bus.data_m_data_out = 16'h1234;
    bus.data_m_addr     = 19'h00042;
    step();
    checks++;
    if ({bus.q_m_access, bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io} !== {1'b1, 19'h00042, 16'h1234, 1'b1, 2'b01, 1'b1}) begin
      failures++;
      $display("FAIL data_bus: got acc=%b addr=%h dout=%h we=%b bs=%b io=%b expected 1 00042 1234 1 01 1",
               bus.q_m_access, bus.q_m_addr, bus.q_m_data_out, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io);
    end
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'h5A5A;
    #1;
    checks++;
    if ({bus.data_m_ack, bus.instr_m_ack, bus.data_m_data_in} !== {2'b10, 16'h5A5A}) begin
      failures++;
      $display("FAIL data_ack: got dack=%b iack=%b ddata=%h expected 1 0 5a5a",
               bus.data_m_ack, bus.instr_m_ack, bus.data_m_data_in);
    end
    step();
    clear_inputs();
    #1;
    checks++;
    if ({bus.q_m_access, bus.data_m_ack, bus.q_io, bus.q_m_wr_en} !== 4'b0000) begin
      failures++;
      $display("FAIL data_retire: got acc=%b dack=%b io=%b we=%b expected 0000",
               bus.q_m_access, bus.data_m_ack, bus.q_io, bus.q_m_wr_en);
    end
    step();
  endtask

  task automatic test_contention();
    logic [9:0] got;
    int         n;
    got = '0;
    n   = 0;
    bus.instr_m_access = 1'b1;
    bus.instr_m_addr   = 19'h00100;
    bus.data_m_access  = 1'b1;
    bus.data_m_addr    = 19'h00200;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      step();
      bus.q_m_ack = bus.q_m_access;
      #1;
      if (bus.data_m_ack) begin
        got[n] = 1'b0;
        n++;
      end else if (bus.instr_m_ack) begin
        got[n] = 1'b1;
        n++;
      end
    end
    checks++;
    if (n !== 10) begin
      failures++;
      $display("FAIL contention_count: got %0d grants expected 10", n);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (got[i] !== ((i == 4) || (i == 9))) begin
        failures++;
        $display("FAIL contention_grant%0d: got %s expected %s", i,
                 got[i] ? "I" : "D", ((i == 4) || (i == 9)) ? "I" : "D");
      end
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_stale();
    bus.instr_m_access = 1'b1;
    bus.instr_m_addr   = 19'h00010;
    step();
    bus.q_m_ack = 1'b1;
    #1;
    checks++;
    if (bus.instr_m_ack !== 1'b1) begin
      failures++;
      $display("FAIL stale_ack: got %b expected 1", bus.instr_m_ack);
    end
    step();
    bus.q_m_ack = 1'b0;
    #1;
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack} !== 2'b00) begin
      failures++;
      $display("FAIL stale_retire: got acc/ack=%b expected 00", {bus.q_m_access, bus.instr_m_ack});
    end
    step();
    bus.instr_m_access = 1'b0;
    #1;
    checks++;
    if (bus.q_m_access !== 1'b0) begin
      failures++;
      $display("FAIL stale_idle: got %b expected 0", bus.q_m_access);
    end
    step();
    checks++;
    if (bus.q_m_access !== 1'b0) begin
      failures++;
      $display("FAIL stale_regrant: got %b expected 0", bus.q_m_access);
    end
    bus.instr_m_access = 1'b1;
    step();
    checks++;
    if (bus.q_m_access !== 1'b1) begin
      failures++;
      $display("FAIL stale_newgrant: got %b expected 1", bus.q_m_access);
    end
    bus.q_m_ack = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_abort();
    bus.instr_m_access = 1'b1;
    bus.instr_m_addr   = 19'h00333;
    step();
    checks++;
    if (bus.q_m_access !== 1'b1 || bus.q_m_bytesel !== 2'b11) begin
      failures++;
      $display("FAIL abort_grant: got acc=%b bs=%b expected 1 11", bus.q_m_access, bus.q_m_bytesel);
    end
    bus.instr_m_access = 1'b0;
    bus.data_m_access  = 1'b1;
    bus.data_m_addr    = 19'h00444;
    bus.data_m_bytesel = 2'b10;
    #1;
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack, bus.data_m_ack} !== 3'b000) begin
      failures++;
      $display("FAIL abort_drop: got %b expected 000", {bus.q_m_access, bus.instr_m_ack, bus.data_m_ack});
    end
    step();
    bus.q_m_ack = 1'b1;
    #1;
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack, bus.data_m_ack} !== 3'b000) begin
      failures++;
      $display("FAIL abort_late_ack: got %b expected 000", {bus.q_m_access, bus.instr_m_ack, bus.data_m_ack});
    end
    step();
    bus.q_m_ack = 1'b0;
    #1;
    checks++;
    if ({bus.q_m_access, bus.q_m_addr, bus.q_m_bytesel} !== {1'b1, 19'h00444, 2'b10}) begin
      failures++;
      $display("FAIL abort_data_grant: got acc=%b addr=%h bs=%b expected 1 00444 10",
               bus.q_m_access, bus.q_m_addr, bus.q_m_bytesel);
    end
    bus.q_m_ack = 1'b1;
    #1;
    checks++;
    if ({bus.data_m_ack, bus.instr_m_ack} !== 2'b10) begin
      failures++;
      $display("FAIL abort_data_ack: got dack/iack=%b expected 10", {bus.data_m_ack, bus.instr_m_ack});
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    bus.instr_m_access = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_addr    = 19'h01234;
    bus.data_m_wr_en   = 1'b1;
    bus.data_m_bytesel = 2'b11;
    step();
    checks++;
    if (bus.q_m_access !== 1'b1 || dut.starve_cnt_q !== 3'd1) begin
      failures++;
      $display("FAIL midreset_setup: got acc=%b starve=%0d expected 1 1", bus.q_m_access, dut.starve_cnt_q);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bus.q_m_access, bus.instr_m_ack, bus.data_m_ack, bus.q_m_addr, bus.q_m_wr_en, bus.q_m_bytesel, bus.q_io} !== 27'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got acc=%b addr=%h we=%b bs=%b expected all 0",
               bus.q_m_access, bus.q_m_addr, bus.q_m_wr_en, bus.q_m_bytesel);
    end
    checks++;
    if (dut.state_q !== 2'd0 || dut.starve_cnt_q !== 3'd0) begin
      failures++;
      $display("FAIL midreset_state: got state=%0d starve=%0d expected 0 0", dut.state_q, dut.starve_cnt_q);
    end
    clear_inputs();
    reset = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_fetch();
    test_data_io();
    test_contention();
    test_stale();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Sits directly downstream of the CPU core.
- Merges the core's instruction-fetch master port and data master port onto one 16-bit memory/IO bus.
- Data accesses take priority over fetches, with an anti-starvation limit so prefetch always makes progress.
- The memory side sees one transaction at a time, using the same access/ack handshake as the core ports.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants issued while a fetch is pending; the next contended grant then goes to instruction. Legal range is ≥1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- instr_m_addr  input  19  fetch word address [19:1]
- instr_m_data_in  output  16  fetch read data
- instr_m_access  input  1  fetch request, held until ack
- instr_m_ack  output  1  fetch completion strobe
- data_m_addr  input  19  data word address [19:1]
- data_m_data_in  output  16  data read data
- data_m_data_out  input  16  data write data
- data_m_access  input  1  data request, held until ack
- data_m_ack  output  1  data completion strobe
- data_m_wr_en  input  1  data write enable
- data_m_bytesel  input  2  data byte lanes
- d_io  input  1  data access targets IO space
- q_m_addr  output  19  memory-side word address
- q_m_data_in  input  16  memory-side read data
- q_m_data_out  output  16  memory-side write data
- q_m_access  output  1  memory-side request
- q_m_ack  input  1  memory-side completion
- q_m_wr_en  output  1  memory-side write enable
- q_m_bytesel  output  2  memory-side byte lanes
- q_io  output  1  memory-side IO qualifier

Behaviour:
- State machine states: IDLE, SERVE_I, SERVE_D, RETIRE. Reset forces IDLE and clears the starvation counter, from any state including mid-transaction.
- Memory-side outputs in IDLE/RETIRE: q_m_access=0, q_m_addr=0, q_m_data_out=0, q_m_wr_en=0, q_m_bytesel=0, q_io=0.
- Master-side outputs in IDLE/RETIRE: both acks are 0.
- instr_m_data_in and data_m_data_in are always driven combinationally from q_m_data_in. Masters sample read data only on their own ack.
- Arbitration happens in IDLE only. The choice is registered, and the granted access appears on q_m_access the next cycle (1-cycle grant latency).
  - data_m_access only → SERVE_D.
  - instr_m_access only → SERVE_I.
  - Both asserted → SERVE_D, unless starve_cnt == STARVE_LIMIT, in which case → SERVE_I.
  - Neither asserted → stay in IDLE.
- starve_cnt, width $clog2(STARVE_LIMIT+1), updates only on a grant:
  - Data grant with instr_m_access high: increment, saturating at STARVE_LIMIT.
  - Data grant with instr_m_access low: clear.
  - Instruction grant: clear.
- SERVE_D: q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel and q_io pass combinationally from the data port. q_m_access = data_m_access.
- SERVE_I: q_m_addr = instr_m_addr, q_m_wr_en=0, q_m_bytesel=2'b11, q_io=0, q_m_data_out=0. q_m_access = instr_m_access.
- Ack routing: q_m_ack is forwarded combinationally, same cycle, to the granted master only, gated by that master's access. The other master's ack is 0.
- Completion: q_m_ack high with the granted master's access high → RETIRE next cycle.
- RETIRE lasts exactly 1 cycle and issues no grant, so a request still asserted in the cycle after its ack is not re-granted. RETIRE → IDLE.
- Abort: if the granted master deasserts access before ack (e.g. a prefetch flush), q_m_access drops in the same cycle and the state goes → IDLE next cycle.
- A q_m_ack arriving in IDLE or RETIRE, or arriving with the granted master's access low, is ignored: no master sees an ack.
- Back-to-back throughput: ack in cycle M, RETIRE in M+1, IDLE in M+2, next q_m_access in M+3.
- Exactly one master is granted at any time. q_m_access never asserts in IDLE or RETIRE.

Test Plan:
- Fetch only: instr_m_access=1, addr=0x7FFF0, memory acks 2 cycles after access with data 0xBEEF. Required: q_m_access rises 1 cycle after request; q_m_addr=0x7FFF0, bytesel=11, wr_en=0; instr_m_ack pulses with instr_m_data_in=0xBEEF; data_m_ack stays 0.
- Data write on IO: data_m_access=1, wr_en=1, bytesel=01, d_io=1, data_out=0x1234, addr=0x00042. Required: q_m_* mirror these values and q_io=1; data_m_ack pulses for 1 cycle; the following RETIRE cycle has q_m_access=0.
- Contention with STARVE_LIMIT=4: both masters request continuously, memory acks immediately. Required grant sequence D,D,D,D,I,D,D,D,D,I.
- Stale request: master holds access for 1 cycle after its ack. Required: no second q_m_access; the next grant occurs only after RETIRE and only if access is still high in IDLE.
- Abort: fetch granted, instr_m_access drops before ack, then q_m_ack=1 arrives 1 cycle later. Required: q_m_access falls the same cycle; no ack reaches either master; a pending data request is granted next.
- Reset mid-SERVE_D: assert reset during a pending transaction. Required: next cycle the state is IDLE, all outputs are 0 and starve_cnt=0.
